// File: rtl/commit_trace_buffer.sv
// Commit-stage trace buffer: rolling capture of retired instructions, PC-match
// trigger with a fixed post-trigger window, then an oldest-first valid/ready readout.
module commit_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic                       cap_valid,
  input  logic [DATA_W-1:0]          cap_pc,
  input  logic [DATA_W-1:0]          cap_instr,
  input  logic [DATA_W-1:0]          cap_alu,
  input  logic                       cap_regwrite,
  input  logic                       cap_memwrite,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]          rd_instr,
  output logic [DATA_W-1:0]          rd_alu,
  output logic                       rd_regwrite,
  output logic                       rd_memwrite,
  output logic                       rd_is_trig,
  output logic                       rd_last,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] alu;
    logic              regwrite;
    logic              memwrite;
  } rec_t;

  state_t          st, st_next;
  rec_t            mem [DEPTH];
  logic [DEPTH-1:0] trig_flag;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_base;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   rd_num;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   post_cnt;
  logic            hit, wr_en, trig_wr, rd_fire, last;
  rec_t            rd_rec;

  assign hit     = cap_valid && trig_en && (cap_pc == trig_pc);
  assign wr_en   = !reset && !arm && cap_valid && (st == S_ARMED || st == S_POST);
  assign trig_wr = wr_en && (st == S_ARMED) && hit;

  // A full buffer has wrapped, so its oldest record sits at the write pointer.
  assign rd_base  = (count_q == CW'(DEPTH)) ? wr_ptr : '0;
  assign rd_ptr   = rd_base + rd_num[AW-1:0];
  assign rd_valid = (st == S_DONE);
  assign last     = rd_valid && (rd_num == count_q - CW'(1));
  assign rd_fire  = rd_valid && rd_ready;
  assign rd_rec   = mem[rd_ptr];

  always_comb begin
    // NOTE: default first so every path assigns st_next and no latch is inferred.
    st_next = st;
    if (arm) begin
      st_next = S_ARMED;
    end else begin
      case (st)
        S_IDLE:  st_next = S_IDLE;
        S_ARMED: if (trig_wr) st_next = (POST_TRIG == 0) ? S_DONE : S_POST;
        S_POST:  if (wr_en && post_cnt == CW'(1)) st_next = S_DONE;
        S_DONE:  if (rd_fire && last) st_next = S_IDLE;
        default: st_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so all flops update together at the edge.
    if (reset) st <= S_IDLE;
    else       st <= st_next;
  end

  always_ff @(posedge clock) begin
    if (reset || arm) begin
      wr_ptr    <= '0;
      count_q   <= '0;
      post_cnt  <= '0;
      rd_num    <= '0;
      trig_flag <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr            <= wr_ptr + 1'b1;
        trig_flag[wr_ptr] <= trig_wr;
        if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
      end
      if (trig_wr)                 post_cnt <= CW'(POST_TRIG);
      else if (wr_en && st == S_POST) post_cnt <= post_cnt - CW'(1);
      if (rd_fire) rd_num <= last ? '0 : rd_num + CW'(1);
    end
  end

  // NOTE: record storage has no reset; only the trig flags and pointers need a known value.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= '{pc: cap_pc, instr: cap_instr, alu: cap_alu,
                                regwrite: cap_regwrite, memwrite: cap_memwrite};
  end

  assign rd_pc       = rd_valid ? rd_rec.pc       : '0;
  assign rd_instr    = rd_valid ? rd_rec.instr    : '0;
  assign rd_alu      = rd_valid ? rd_rec.alu      : '0;
  assign rd_regwrite = rd_valid && rd_rec.regwrite;
  assign rd_memwrite = rd_valid && rd_rec.memwrite;
  assign rd_is_trig  = rd_valid && trig_flag[rd_ptr];
  assign rd_last     = last;
  assign state       = st;
  assign count       = count_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: a record-queue model of the capture
// window acts as the scoreboard for readout, plus table vectors and corner sequences.
module tb_commit_trace_buffer;

  logic        clock = 1'b0;
  logic        reset, arm, trig_en, cap_valid, cap_regwrite, cap_memwrite, rd_ready;
  logic [31:0] trig_pc, cap_pc, cap_instr, cap_alu;
  logic        rd_valid, rd_regwrite, rd_memwrite, rd_is_trig, rd_last;
  logic [31:0] rd_pc, rd_instr, rd_alu;
  logic [1:0]  state;
  logic [4:0]  count;

  commit_trace_buffer #(.DATA_W(32), .DEPTH(16), .POST_TRIG(4)) dut (
    .clock(clock), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr), .cap_alu(cap_alu),
    .cap_regwrite(cap_regwrite), .cap_memwrite(cap_memwrite), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_alu(rd_alu),
    .rd_regwrite(rd_regwrite), .rd_memwrite(rd_memwrite), .rd_is_trig(rd_is_trig),
    .rd_last(rd_last), .state(state), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic        rw;
    logic        mw;
    logic        trig;
  } rec_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  exp_state;
    logic [4:0]  exp_count;
  } vec_t;

  rec_t q[$];
  int   m_st;
  int   m_post;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] alu_of(input logic [31:0] pc);
    return pc + 32'h0000_1234;
  endfunction

  // Drive one cycle of commit input and update the window model.
  task automatic cap(input logic v, input logic [31:0] pc);
    rec_t r;
    cap_valid    = v;
    cap_pc       = pc;
    cap_instr    = instr_of(pc);
    cap_alu      = alu_of(pc);
    cap_regwrite = pc[2];
    cap_memwrite = pc[3];
    tick();
    cap_valid = 1'b0;
    if (v && (m_st == 1 || m_st == 2)) begin
      r = '{pc: pc, instr: instr_of(pc), alu: alu_of(pc), rw: pc[2], mw: pc[3],
            trig: (m_st == 1) && trig_en && (pc == trig_pc)};
      q.push_back(r);
      if (q.size() > 16) void'(q.pop_front());
      if (r.trig) begin
        m_st = 2;
        m_post = 4;
      end else if (m_st == 2) begin
        m_post--;
        if (m_post == 0) m_st = 3;
      end
    end
  endtask

  task automatic do_arm(input logic with_cap);
    arm = 1'b1;
    if (with_cap) begin
      cap_valid = 1'b1;
      cap_pc    = trig_pc;
    end
    tick();
    arm = 1'b0;
    cap_valid = 1'b0;
    q.delete();
    m_st = 1;
    check("arm_state", state, 1);
    check("arm_count", count, 0);
  endtask

  // Pop and compare up to 'limit' records; optional 3-cycle stall before record stall_at.
  task automatic drain(input int stall_at, input int limit);
    int   n;
    int   n_rd;
    rec_t e;
    n    = q.size();
    n_rd = (limit < n) ? limit : n;
    for (int k = 0; k < n_rd; k++) begin
      e = q[0];
      check("rd_valid", rd_valid, 1);
      check("rd_pc", rd_pc, e.pc);
      check("rd_instr", rd_instr, e.instr);
      check("rd_alu", rd_alu, e.alu);
      check("rd_flags", {rd_regwrite, rd_memwrite}, {e.rw, e.mw});
      check("rd_is_trig", rd_is_trig, e.trig);
      check("rd_last", rd_last, (k == n - 1));
      if (k == stall_at) begin
        rd_ready = 1'b0;
        repeat (3) begin
          tick();
          check("stall_pc", rd_pc, e.pc);
          check("stall_valid", rd_valid, 1);
        end
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      void'(q.pop_front());
    end
    if (n_rd == n) begin
      m_st = 0;
      check("post_read_state", state, 0);
      check("post_read_valid", rd_valid, 0);
      check("post_read_pc", rd_pc, 0);
      check("post_read_trig", rd_is_trig, 0);
      check("post_read_count", count, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{32'h00, 2'd1, 5'd1};
    vecs[1] = '{32'h04, 2'd1, 5'd2};
    vecs[2] = '{32'h08, 2'd2, 5'd3};
    vecs[3] = '{32'h0C, 2'd2, 5'd4};
    vecs[4] = '{32'h10, 2'd2, 5'd5};
    vecs[5] = '{32'h14, 2'd2, 5'd6};
    vecs[6] = '{32'h18, 2'd3, 5'd7};

    reset = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; cap_valid = 1'b0;
    cap_pc = '0; cap_instr = '0; cap_alu = '0; cap_regwrite = 1'b0; cap_memwrite = 1'b0;
    rd_ready = 1'b0; m_st = 0; m_post = 0;

    // Reset values
    repeat (2) tick();
    check("reset_state", state, 0);
    check("reset_count", count, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", {rd_pc, rd_instr}, 0);
    check("reset_rd_alu", rd_alu, 0);
    check("reset_rd_flags", {rd_regwrite, rd_memwrite, rd_is_trig, rd_last}, 0);
    reset = 1'b0;
    tick();

    // Basic window, table driven
    trig_en = 1'b1;
    trig_pc = 32'h08;
    do_arm(1'b0);
    for (int i = 0; i < 7; i++) begin
      cap(1'b1, vecs[i].pc);
      check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
    end
    check("basic_third_is_trig", q[2].trig, 1);
    drain(-1, 99);

    // Wrap with backpressure mid-read
    trig_pc = 32'd100;
    do_arm(1'b0);
    for (int i = 0; i < 30; i++) cap(1'b1, 32'(4 * i));
    check("wrap_state", state, 3);
    check("wrap_count", count, 16);
    check("wrap_first_pc", rd_pc, 32'd56);
    check("wrap_trig_pc", q[11].pc, 32'h64);
    drain(5, 99);

    // Gaps during POST, second PC match ignored
    trig_pc = 32'h40;
    do_arm(1'b0);
    cap(1'b1, 32'h3C);
    cap(1'b1, 32'h40);
    check("gap_post", state, 2);
    cap(1'b0, 32'h40);
    cap(1'b1, 32'h44);
    cap(1'b0, 32'h00);
    cap(1'b1, 32'h40);
    cap(1'b0, 32'h00);
    cap(1'b0, 32'h00);
    cap(1'b1, 32'h48);
    check("gap_still_post", state, 2);
    cap(1'b0, 32'h00);
    check("gap_idle_cycle", state, 2);
    cap(1'b1, 32'h4C);
    check("gap_done", state, 3);
    check("gap_count", count, 6);
    drain(-1, 99);

    // Re-arm during POST, with a same-cycle matching capture
    do_arm(1'b0);
    cap(1'b1, 32'h40);
    cap(1'b1, 32'h44);
    check("rearm_in_post", state, 2);
    do_arm(1'b1);

    // No trigger: rolling window
    trig_en = 1'b0;
    for (int i = 0; i < 40; i++) cap(1'b1, 32'h1000 + 32'(4 * i));
    check("notrig_state", state, 1);
    check("notrig_count", count, 16);

    // Trigger late, then reset in the middle of the readout
    trig_en = 1'b1;
    trig_pc = 32'h2000;
    for (int i = 0; i < 5; i++) cap(1'b1, 32'h2000 + 32'(4 * i));
    check("late_trig_state", state, 3);
    check("late_trig_count", count, 16);
    drain(-1, 3);
    reset = 1'b1;
    rd_ready = 1'b1;
    tick();
    reset = 1'b0;
    rd_ready = 1'b0;
    q.delete();
    m_st = 0;
    check("midread_reset_state", state, 0);
    check("midread_reset_valid", rd_valid, 0);
    check("midread_reset_count", count, 0);
    check("midread_reset_pc", rd_pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
